// File: rtl/ws2812_pkg.sv
// ws2812_pkg: WS2812 types, protocol timings and cycle-delay helpers.
// Shared by the LED transmitter and the ws2812_rx decoder.
package ws2812_pkg;

  typedef enum logic [1:0] {
    RESYNC,
    IDLE,
    HIGH,
    LOW
  } rx_state_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  // Protocol timings in ns
  localparam longint unsigned RX_THR_NS   = 600;
  localparam longint unsigned RX_MAXHI_NS = 2_000;
  localparam longint unsigned TX_T0H_NS   = 400;
  localparam longint unsigned TX_T1H_NS   = 800;
  localparam longint unsigned TX_T0L_NS   = 850;
  localparam longint unsigned TX_T1L_NS   = 450;
  localparam longint unsigned TX_RES_NS   = 50_000;

  function automatic logic [15:0] dly_cyc(
    input longint unsigned clk_hz,
    input longint unsigned ns
  );
    longint unsigned c;
    c = clk_hz * ns / 64'd1_000_000_000;
    return c[15:0];
  endfunction

  function automatic logic [15:0] dly_us(
    input longint unsigned clk_hz,
    input longint unsigned us
  );
    return dly_cyc(clk_hz, us * 64'd1000);
  endfunction

endpackage

// File: rtl/ws2812_rx_sync2.sv
// sync2: generic two-flop synchroniser with synchronous active-high reset.
// Brings an asynchronous bus into the clk domain.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire decoder producing 24-bit GRB pixels.
// Define WS2812_RX_FWD_EN to add the chained-LED forward output ws2812_o.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_SPEED = 27_000_000,
  parameter int unsigned RES_US    = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ws2812_i,
  output logic        pix_valid,
  output logic [7:0]  g,
  output logic [7:0]  r,
  output logic [7:0]  b,
  output logic [15:0] pix_idx,
  output logic        frame_done,
  output logic        err
`ifdef WS2812_RX_FWD_EN
  ,
  output logic        ws2812_o
`endif
);

  localparam logic [15:0] DLY_THR =
    dly_cyc(64'(CLK_SPEED), RX_THR_NS);
  localparam logic [15:0] DLY_MAXHI =
    dly_cyc(64'(CLK_SPEED), RX_MAXHI_NS);
  localparam logic [15:0] DLY_RES =
    dly_us(64'(CLK_SPEED), 64'(RES_US));

  logic        line;
  logic        line_d;
  logic        rise;
  logic        fall;
  logic [15:0] cnt;

  rx_state_t   state;
  rx_state_t   state_nx;

  logic [4:0]  bitcnt;
  logic [22:0] sr;
  logic        bit_val;
  logic [23:0] word;
  pixel_t      pix;

  logic        do_shift;
  logic        do_pix;
  logic        do_frame;
  logic        do_err;
  logic        do_clr;

  sync2 #(.W(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ws2812_i),
    .q   (line)
  );

  always_ff @(posedge clk) begin
    if (rst) line_d <= 1'b0;
    else     line_d <= line;
  end

  assign rise = line & ~line_d;
  assign fall = ~line & line_d;

  // Edge-relative cycle counter, saturating
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (rise || fall)    cnt <= 16'd1;
    else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end

  assign bit_val = cnt > DLY_THR;
  assign word    = {sr, bit_val};

  always_ff @(posedge clk) begin
    if (rst) state <= RESYNC;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RESYNC: begin
        if (!line && !line_d && cnt >= DLY_RES)
          state_nx = IDLE;
      end
      IDLE: begin
        if (rise) state_nx = HIGH;
      end
      HIGH: begin
        if (fall)                   state_nx = LOW;
        else if (cnt == DLY_MAXHI)  state_nx = RESYNC;
      end
      LOW: begin
        if (rise)                 state_nx = HIGH;
        else if (cnt == DLY_RES)  state_nx = IDLE;
      end
      default: state_nx = RESYNC;
    endcase
  end

  always_comb begin
    do_shift = 1'b0;
    do_pix   = 1'b0;
    do_frame = 1'b0;
    do_err   = 1'b0;
    do_clr   = 1'b0;
    unique case (state)
      HIGH: begin
        if (fall) begin
          do_shift = 1'b1;
          do_pix   = bitcnt == 5'd23;
        end else if (cnt == DLY_MAXHI) begin
          do_err = 1'b1;
          do_clr = 1'b1;
        end
      end
      LOW: begin
        if (!rise && cnt == DLY_RES) begin
          do_frame = 1'b1;
          do_err   = bitcnt != 5'd0;
          do_clr   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt     <= '0;
      sr         <= '0;
      pix        <= '0;
      pix_idx    <= '0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      pix_valid  <= do_pix;
      frame_done <= do_frame;
      err        <= do_err;
      if (do_clr) begin
        bitcnt <= '0;
        sr     <= '0;
      end else if (do_shift) begin
        sr     <= word[22:0];
        bitcnt <= do_pix ? 5'd0 : bitcnt + 5'd1;
      end
      if (do_pix) pix <= word;
      // Index advances the cycle after its strobe
      if (do_frame)       pix_idx <= '0;
      else if (pix_valid) pix_idx <= pix_idx + 16'd1;
    end
  end

  assign g = pix.g;
  assign r = pix.r;
  assign b = pix.b;

`ifdef WS2812_RX_FWD_EN
  logic fwd_blk;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_blk  <= 1'b0;
      ws2812_o <= 1'b0;
    end else begin
      if (do_frame)    fwd_blk <= 1'b0;
      else if (do_err) fwd_blk <= 1'b1;
      ws2812_o <= line_d
                & (pix_idx != 16'd0)
                & (state != RESYNC)
                & ~fwd_blk
                & ~do_err;
    end
  end
`endif

endmodule
